// File: rtl/osd_pkg.sv
// Shared opcodes, OSD command bytes and controller state encoding
// for the core-side OSD SPI master.
package osd_pkg;

    localparam logic [1:0] OP_DISABLE = 2'd0;
    localparam logic [1:0] OP_ENABLE  = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
    localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;

    localparam int OSD_LINE_BYTES = 256;
    localparam int OSD_LINES      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FETCH,
        GAP
    } state_t;

    // Disable and enable share 0x40; bit 0 selects enable.
    function automatic logic [7:0] cmd_byte(input logic [1:0] op,
                                            input logic [2:0] line);
        if (op == OP_WRITE) begin
            return OSD_CMD_WRITE | {5'd0, line};
        end
        return OSD_CMD_ENABLE | {7'd0, op == OP_ENABLE};
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Shifts one byte MSB first: sck low then high for CLK_DIV clk each,
// sdi changes only on sck fall (or at load).
module spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic       sck_o,
    output logic       sdi_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);

    logic          active_q;
    logic [7:0]    shreg_q;
    logic [2:0]    bit_q;
    logic [DW-1:0] div_q;
    logic          sck_q;
    logic          sdi_q;
    logic          half_end;

    assign half_end = (div_q == DIV_END);
    assign done_o   = active_q && sck_q && half_end && (bit_q == 3'd7);
    assign sck_o    = sck_q;
    assign sdi_o    = sdi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            shreg_q  <= 8'd0;
            bit_q    <= 3'd0;
            div_q    <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
        end else if (load_i) begin
            active_q <= 1'b1;
            shreg_q  <= byte_i;
            bit_q    <= 3'd0;
            div_q    <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= byte_i[7];
        end else if (active_q) begin
            if (half_end) begin
                div_q <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                end else begin
                    sck_q <= 1'b0;
                    if (bit_q == 3'd7) begin
                        active_q <= 1'b0;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        shreg_q <= {shreg_q[6:0], 1'b0};
                        sdi_q   <= shreg_q[6];
                    end
                end
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

endmodule

// File: rtl/osd_spi_master.sv
// Drives the OSD overlay SPI slave port from a parallel command
// interface; line writes stream 256 bytes from a 1-cycle byte store.
module osd_spi_master
    import osd_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_line,
    output logic       data_req,
    output logic [7:0] data_addr,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       sck,
    output logic       ss,
    output logic       sdi
);

    localparam int GW = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
    localparam logic [GW-1:0] GAP_END = GW'(SS_GAP - 1);
    localparam logic [8:0] LAST_CNT = 9'(OSD_LINE_BYTES);

    state_t        state_q;
    logic [8:0]    byte_cnt_q;
    logic [GW-1:0] gap_q;
    logic          is_write_q;
    logic          fetch_ph_q;
    logic          ss_q;
    logic          busy_q;
    logic          cmd_ready_q;
    logic          data_req_q;
    logic [7:0]    data_addr_q;

    logic       accept;
    logic       sh_load;
    logic [7:0] sh_byte;
    logic       sh_done;

    assign accept  = (state_q == IDLE) && cmd_ready_q && cmd_valid
                     && (cmd_op != OP_RSVD);
    // Second FETCH cycle is when the store's byte is on data_in.
    assign sh_load = accept || ((state_q == FETCH) && fetch_ph_q);
    assign sh_byte = accept ? cmd_byte(cmd_op, cmd_line) : data_in;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load_i (sh_load),
        .byte_i (sh_byte),
        .done_o (sh_done),
        .sck_o  (sck),
        .sdi_o  (sdi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 9'd0;
            gap_q       <= '0;
            is_write_q  <= 1'b0;
            fetch_ph_q  <= 1'b0;
            ss_q        <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            data_req_q  <= 1'b0;
            data_addr_q <= 8'd0;
        end else begin
            data_req_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        state_q     <= SHIFT;
                        ss_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        is_write_q  <= (cmd_op == OP_WRITE);
                        byte_cnt_q  <= 9'd0;
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        if (is_write_q && (byte_cnt_q != LAST_CNT)) begin
                            state_q     <= FETCH;
                            data_req_q  <= 1'b1;
                            data_addr_q <= byte_cnt_q[7:0];
                            fetch_ph_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                            ss_q    <= 1'b1;
                            gap_q   <= '0;
                        end
                    end
                end
                FETCH: begin
                    fetch_ph_q <= 1'b1;
                    if (fetch_ph_q) begin
                        byte_cnt_q <= byte_cnt_q + 9'd1;
                        state_q    <= SHIFT;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_END) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign ss        = ss_q;
    assign data_req  = data_req_q;
    assign data_addr = data_addr_q;

endmodule

// File: tb/tb_osd_spi_master.sv
// Scoreboard bench: a behavioural SPI slave decodes sdi on sck rise
// and compares each byte against what the issued commands imply.
module tb_osd_spi_master;

    localparam int CD = 2;
    localparam int SG = 4;
    localparam int WR_LEN = 257 * 16 * CD + 256 * 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_line = 3'd0;
    logic [7:0] data_in = 8'd0;
    logic       cmd_ready;
    logic       data_req;
    logic [7:0] data_addr;
    logic       busy;
    logic       sck;
    logic       ss;
    logic       sdi;

    osd_spi_master #(
        .CLK_DIV (CD),
        .SS_GAP  (SG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_line  (cmd_line),
        .data_req  (data_req),
        .data_addr (data_addr),
        .data_in   (data_in),
        .busy      (busy),
        .sck       (sck),
        .ss        (ss),
        .sdi       (sdi)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp_q[$];
    int len_q[$];
    int pul_q[$];

    int cyc = 0, low = 0, high = SG, pulses = 0, nbits = 0;
    int rise_cyc = 0, n_req = 0, n_fall = 0, n_busy = 0;
    int exp_addr = 0;
    logic [7:0] sh = 8'd0;
    logic [7:0] addr_d = 8'd0;
    logic ss_p = 1'b1, sck_p = 1'b0, busy_p = 1'b0, req_d = 1'b0;

    // Byte store (1-cycle latency) plus SPI slave monitor.
    always @(negedge clk) begin
        cyc++;
        data_in = req_d ? (addr_d ^ 8'hA5) : 8'h00;
        req_d = data_req;
        addr_d = data_addr;
        if (reset) begin
            req_d = 1'b0;
            nbits = 0;
            low = 0;
            pulses = 0;
            high = SG;
        end else begin
            if (data_req) begin
                chk("data_addr", data_addr, exp_addr);
                exp_addr++;
                n_req++;
            end
            if (busy) n_busy++;
            if (ss && sck) chk("sck_idle_when_ss_high", sck, 0);
            if (!ss) begin
                low++;
                if (sck && !sck_p) begin
                    sh = {sh[6:0], sdi};
                    nbits++;
                    pulses++;
                    if (nbits == 8) begin
                        nbits = 0;
                        if (exp_q.size() == 0) chk("extra_byte", sh, -1);
                        else chk("spi_byte", sh, exp_q.pop_front());
                    end
                end
            end else begin
                high++;
            end
            if (!ss && ss_p) begin
                n_fall++;
                chk("ss_gap_min", int'(high >= SG), 1);
                high = 0;
            end
            if (ss && !ss_p) begin
                if (len_q.size() == 0) begin
                    chk("extra_txn", 1, 0);
                end else begin
                    chk("ss_low_len", low, len_q.pop_front());
                    chk("sck_pulses", pulses, pul_q.pop_front());
                end
                chk("partial_bits", nbits, 0);
                rise_cyc = cyc;
                low = 0;
                pulses = 0;
                nbits = 0;
            end
            if (!busy && busy_p) chk("busy_after_ss", cyc - rise_cyc, SG);
        end
        ss_p = ss;
        sck_p = sck;
        busy_p = busy;
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] line);
        bit acc = 1'b0;
        cmd_op = op;
        cmd_line = line;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20000 && !acc; i++) begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_line = 3'($urandom);
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        if (op == 2'd2) begin
            exp_q.push_back(32'h20 | int'(line));
            for (int i = 0; i < 256; i++) exp_q.push_back((i ^ 'hA5) & 'hFF);
            len_q.push_back(WR_LEN);
            pul_q.push_back(8 + 2048);
            exp_addr = 0;
        end else begin
            exp_q.push_back(op == 2'd1 ? 'h41 : 'h40);
            len_q.push_back(16 * CD);
            pul_q.push_back(8);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (!busy && cmd_ready) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk(tag, 0, 1);
    endtask

    int f0, r0, b0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", ss, 1);
        chk("rst_sck", sck, 0);
        chk("rst_sdi", sdi, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_req", data_req, 0);
        chk("rst_data_addr", data_addr, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_after_reset", cmd_ready, 1);

        issue(2'd1, 3'd0);
        chk("busy_on_accept", busy, 1);
        chk("ss_on_accept", ss, 0);
        chk("ready_on_accept", cmd_ready, 0);
        wait_idle("idle_timeout_enable");

        issue(2'd0, 3'd0);
        issue(2'd1, 3'd0);
        wait_idle("idle_timeout_b2b");

        f0 = n_fall;
        r0 = n_req;
        b0 = n_busy;
        cmd_op = 2'd3;
        cmd_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rsvd_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rsvd_ss_falls", n_fall - f0, 0);
        chk("rsvd_reqs", n_req - r0, 0);
        chk("rsvd_busy", n_busy - b0, 0);

        r0 = n_req;
        issue(2'd2, 3'd5);
        wait_idle("idle_timeout_write");
        chk("write_reqs", n_req - r0, 256);
        chk("write_last_addr", exp_addr, 256);

        r0 = n_req;
        issue(2'd2, 3'd3);
        for (int i = 0; i < 20000 && (n_req - r0) < 100; i++) @(negedge clk);
        chk("abort_reach_100", int'((n_req - r0) >= 100), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ss", ss, 1);
        chk("abort_sck", sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data_req", data_req, 0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        len_q.delete();
        pul_q.delete();
        reset = 1'b0;
        r0 = n_req;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_more_req", n_req - r0, 0);
        issue(2'd1, 3'd0);
        wait_idle("idle_timeout_after_abort");
        repeat (4) @(posedge clk);
        #1;
        chk("bytes_left", exp_q.size(), 0);
        chk("txns_left", len_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
